satatrn_txsched: RTL and testbench



---
 rtl/satatrn_txsched.sv | 272 +++++++++++++++++++++++++++
 tb/tb_satatrn_txsched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satatrn_txsched.sv
`default_nettype none
// ============================================================================
// Module      : satatrn_txsched
// Description : SATA transport-layer transmit FIS scheduler. Sends one frame
//               at a time to the link layer. Register FISes are captured in a
//               local buffer so they can be replayed on R_ERR (up to MAXRETRY
//               times). Data frames are prefixed with the FIS_DATA header
//               word (0x46) and are never replayed.
// Ports       : i_clk, i_reset_n         - PHY clock, async active-low reset
//               i_reg_*  / o_reg_ready   - register FIS source stream
//               i_txgate                 - DMA Activate seen, data may go
//               i_data_* / o_data_ready  - data payload source stream
//               o_valid/i_ready/o_data/o_last - link-layer transmit stream
//               i_link_done/i_link_err   - frame status (R_ERR when err=1)
//               o_reg_done/o_reg_fail    - register FIS outcome pulses
//               o_data_done/o_data_err   - data frame status pulse + error
//               o_busy                   - scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module satatrn_txsched #(
  parameter int LGBUF        = 3,
  parameter int MAXRETRY     = 3,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_reg_valid,
  output logic        o_reg_ready,
  input  logic [31:0] i_reg_data,
  input  logic        i_reg_last,
  input  logic        i_txgate,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  input  logic [31:0] i_data_data,
  input  logic        i_data_last,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_last,
  input  logic        i_link_done,
  input  logic        i_link_err,
  output logic        o_reg_done,
  output logic        o_reg_fail,
  output logic        o_data_done,
  output logic        o_data_err,
  output logic        o_busy
);

  localparam int DEPTH = 1 << LGBUF;
  localparam int CW    = LGBUF + 1;             // counts 0..DEPTH inclusive
  localparam int RW    = $clog2(MAXRETRY + 2);  // holds 0..MAXRETRY
  localparam logic [31:0] C_FIS_DATA_HDR = 32'h0000_0046;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REG_LOAD  = 3'd1,
    S_REG_SEND  = 3'd2,
    S_DATA_HDR  = 3'd3,
    S_DATA_SEND = 3'd4,
    S_WAIT_STAT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LGBUF-1:0]  wr_q, wr_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     rd_q, rd_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              kind_data_q, kind_data_d;   // frame in flight is a data frame
  logic              last_seen_q, last_seen_d;   // payload i_data_last already taken
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic              reg_done_q, reg_done_d;
  logic              reg_fail_q, reg_fail_d;
  logic              data_done_q, data_done_d;
  logic              data_err_q, data_err_d;
  logic              busy_q;

  logic [31:0]       regbuf_q [DEPTH];
  logic              buf_we;
  logic              reg_ready;
  logic              data_ready;
  logic              out_adv;

  // Output register may take a new word when empty or being drained.
  assign out_adv = !valid_q || i_ready;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    len_d       = len_q;
    rd_d        = rd_q;
    retry_d     = retry_q;
    kind_data_d = kind_data_q;
    last_seen_d = last_seen_q;
    valid_d     = valid_q;
    data_d      = data_q;
    last_d      = last_q;
    reg_done_d  = 1'b0;
    reg_fail_d  = 1'b0;
    data_done_d = 1'b0;
    data_err_d  = 1'b0;
    buf_we      = 1'b0;
    reg_ready   = 1'b0;
    data_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_txgate && i_data_valid) begin
          state_d = S_DATA_HDR;
        end else if (i_reg_valid) begin
          state_d = S_REG_LOAD;
        end
      end

      S_REG_LOAD: begin
        reg_ready = 1'b1;
        if (i_reg_valid) begin
          buf_we = 1'b1;
          // The top buffer slot always terminates the FIS.
          if (i_reg_last || (&wr_q)) begin
            len_d   = {1'b0, wr_q} + CW'(1);
            rd_d    = '0;
            retry_d = '0;
            wr_d    = '0;
            state_d = S_REG_SEND;
          end else begin
            wr_d = wr_q + LGBUF'(1);
          end
        end
      end

      S_REG_SEND: begin
        if (out_adv) begin
          if (rd_q < len_q) begin
            valid_d = 1'b1;
            data_d  = regbuf_q[rd_q[LGBUF-1:0]];
            last_d  = (rd_q == (len_q - CW'(1)));
            rd_d    = rd_q + CW'(1);
          end else begin
            valid_d = 1'b0;
          end
        end
        if (valid_q && last_q && i_ready) begin
          state_d     = S_WAIT_STAT;
          kind_data_d = 1'b0;
          valid_d     = 1'b0;
        end
      end

      S_DATA_HDR: begin
        if (out_adv) begin
          valid_d     = 1'b1;
          data_d      = C_FIS_DATA_HDR;
          last_d      = 1'b0;
          last_seen_d = 1'b0;
          state_d     = S_DATA_SEND;
        end
      end

      S_DATA_SEND: begin
        data_ready = out_adv && !last_seen_q;
        if (data_ready && i_data_valid) begin
          valid_d = 1'b1;
          data_d  = i_data_data;
          last_d  = i_data_last;
          if (i_data_last) begin
            last_seen_d = 1'b1;
          end
        end else if (i_ready) begin
          valid_d = 1'b0;
        end
        // Once the payload last word is taken, nothing else can load, so the
        // accepted o_last word is always the final payload word.
        if (valid_q && last_q && i_ready) begin
          state_d     = S_WAIT_STAT;
          kind_data_d = 1'b1;
          valid_d     = 1'b0;
          last_seen_d = 1'b0;
        end
      end

      S_WAIT_STAT: begin
        valid_d = 1'b0;
        if (i_link_done) begin
          if (kind_data_q) begin
            data_done_d = 1'b1;
            data_err_d  = i_link_err;
            state_d     = S_IDLE;
          end else if (!i_link_err) begin
            reg_done_d = 1'b1;
            state_d    = S_IDLE;
          end else if (retry_q < RW'(MAXRETRY)) begin
            retry_d = retry_q + RW'(1);
            rd_d    = '0;
            state_d = S_REG_SEND;
          end else begin
            reg_fail_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (OPT_LOWPOWER && !valid_d) begin
      data_d = '0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      wr_q        <= '0;
      len_q       <= '0;
      rd_q        <= '0;
      retry_q     <= '0;
      kind_data_q <= 1'b0;
      last_seen_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      reg_done_q  <= 1'b0;
      reg_fail_q  <= 1'b0;
      data_done_q <= 1'b0;
      data_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      rd_q        <= rd_d;
      retry_q     <= retry_d;
      kind_data_q <= kind_data_d;
      last_seen_q <= last_seen_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      reg_done_q  <= reg_done_d;
      reg_fail_q  <= reg_fail_d;
      data_done_q <= data_done_d;
      data_err_q  <= data_err_d;
      // Registered from the current state so busy drops one cycle after the
      // status pulse that returns the scheduler to IDLE.
      busy_q      <= (state_q != S_IDLE);
    end
  end

  // Buffer storage needs no reset: len/rd gate every read.
  always_ff @(posedge i_clk) begin
    if (buf_we) begin
      regbuf_q[wr_q] <= i_reg_data;
    end
  end

  assign o_reg_ready  = reg_ready;
  assign o_data_ready = data_ready;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_last       = last_q;
  assign o_reg_done   = reg_done_q;
  assign o_reg_fail   = reg_fail_q;
  assign o_data_done  = data_done_q;
  assign o_data_err   = data_err_q;
  assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_satatrn_txsched.sv
`default_nettype none
// ============================================================================
// Module      : tb_satatrn_txsched
// Description : Directed self-checking bench for satatrn_txsched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_satatrn_txsched;

  logic        clk;
  logic        rst_n;
  logic        i_reg_valid, i_reg_last, i_txgate, i_data_valid, i_data_last;
  logic [31:0] i_reg_data, i_data_data;
  logic        i_ready, i_link_done, i_link_err;
  logic        o_reg_ready, o_data_ready, o_valid, o_last;
  logic [31:0] o_data;
  logic        o_reg_done, o_reg_fail, o_data_done, o_data_err, o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int reg_done_cnt = 0, reg_fail_cnt = 0, data_done_cnt = 0;
  logic last_data_err = 1'b0;
  bit   bp_en = 1'b0;
  logic [32:0] out_q [$];
  logic        hold;
  logic [32:0] held;

  satatrn_txsched #(.LGBUF(3), .MAXRETRY(3), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_reg_valid(i_reg_valid), .o_reg_ready(o_reg_ready),
    .i_reg_data(i_reg_data), .i_reg_last(i_reg_last),
    .i_txgate(i_txgate),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .i_data_data(i_data_data), .i_data_last(i_data_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .i_link_done(i_link_done), .i_link_err(i_link_err),
    .o_reg_done(o_reg_done), .o_reg_fail(o_reg_fail),
    .o_data_done(o_data_done), .o_data_err(o_data_err), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, so it sees what the next rising edge will use.
  initial hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", {63'b0, o_valid}, 64'd1);
        check("stall_word", {31'b0, o_last, o_data}, {31'b0, held});
      end
      hold = o_valid && !i_ready;
      held = {o_last, o_data};
      if (o_valid && i_ready) out_q.push_back({o_last, o_data});
      if (o_reg_done) reg_done_cnt++;
      if (o_reg_fail) reg_fail_cnt++;
      if (o_data_done) begin
        data_done_cnt++;
        last_data_err = o_data_err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) i_ready = ~i_ready;
  endtask

  task automatic push_reg(input int first, input int count, input logic [31:0] base, input int last_idx);
    bit acc;
    int t;
    for (int i = first; i < first + count; i++) begin
      i_reg_valid = 1'b1;
      i_reg_data  = base + i;
      i_reg_last  = (i == last_idx);
      t = 0;
      do begin
        @(negedge clk);
        acc = o_reg_ready;
        tick();
        t++;
      end while (!acc && t < 200);
      if (!acc) check("reg_accept_timeout", 64'd0, 64'd1);
    end
    i_reg_valid = 1'b0;
    i_reg_last  = 1'b0;
  endtask

  task automatic push_data(input int first, input int count, input logic [31:0] base,
                           input int last_idx, input bit gaps);
    bit acc;
    int t;
    for (int i = first; i < first + count; i++) begin
      if (gaps && (i % 2 == 1)) begin
        i_data_valid = 1'b0;
        tick();
      end
      i_data_valid = 1'b1;
      i_data_data  = base + i;
      i_data_last  = (i == last_idx);
      t = 0;
      do begin
        @(negedge clk);
        acc = o_data_ready;
        tick();
        t++;
      end while (!acc && t < 200);
      if (!acc) check("data_accept_timeout", 64'd0, 64'd1);
    end
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (out_q.size() < n && t < 300) begin
      tick();
      t++;
    end
    if (out_q.size() < n) check("frame_timeout", out_q.size(), n);
    tick();
    tick();
  endtask

  task automatic check_frame(input string tag, input int first, input int n,
                             input logic [31:0] base, input int last_idx);
    logic [32:0] w;
    logic [32:0] e;
    wait_words(n);
    for (int i = first; i < first + n; i++) begin
      if (out_q.size() > 0) w = out_q.pop_front();
      else w = 'x;
      e = {(i == last_idx), base + i};
      check(tag, {31'b0, w}, {31'b0, e});
    end
  endtask

  task automatic link(input logic err);
    i_link_done = 1'b1;
    i_link_err  = err;
    tick();
    i_link_done = 1'b0;
    i_link_err  = 1'b0;
  endtask

  task automatic pop_hdr(input string tag);
    logic [32:0] w;
    if (out_q.size() > 0) w = out_q.pop_front();
    else w = 'x;
    check(tag, {31'b0, w}, {31'b0, 1'b0, 32'h0000_0046});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_reg_valid = 0; i_reg_last = 0; i_reg_data = '0;
    i_txgate = 0; i_data_valid = 0; i_data_last = 0; i_data_data = '0;
    i_ready = 1'b1; i_link_done = 0; i_link_err = 0;
    tick(); tick();

    // Reset state
    check("rst_valid", {63'b0, o_valid}, 64'd0);
    check("rst_word", {31'b0, o_last, o_data}, 64'd0);
    check("rst_status", {59'b0, o_reg_done, o_reg_fail, o_data_done, o_data_err, o_busy}, 64'd0);
    check("rst_ready", {62'b0, o_reg_ready, o_data_ready}, 64'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Register FIS, R_OK, including load-to-send latency
    push_reg(0, 5, 32'hA000_0000, 4);
    check("reg_lat_m1_valid", {63'b0, o_valid}, 64'd0);
    check("reg_lat_m1_busy", {63'b0, o_busy}, 64'd1);
    tick();
    check("reg_lat_m2_word0", {31'b0, o_valid, o_data}, {31'b0, 1'b1, 32'hA000_0000});
    check_frame("reg_ok_frame", 0, 5, 32'hA000_0000, 4);
    link(1'b0);
    check("reg_done_pulse", {62'b0, o_reg_done, o_busy}, 64'd3);
    tick();
    check("reg_done_after", {62'b0, o_reg_done, o_busy}, 64'd0);
    check("reg_done_cnt1", reg_done_cnt, 64'd1);
    check("reg_ok_no_extra", out_q.size(), 64'd0);

    // Retry: three R_ERR then R_OK -> four frames, one done
    push_reg(0, 5, 32'hB000_0000, 4);
    for (int r = 0; r < 3; r++) begin
      check_frame("retry_frame", 0, 5, 32'hB000_0000, 4);
      link(1'b1);
      if (r == 0) begin
        tick();
        check("replay_k2_word0", {31'b0, o_valid, o_data}, {31'b0, 1'b1, 32'hB000_0000});
      end
    end
    check_frame("retry_frame_last", 0, 5, 32'hB000_0000, 4);
    link(1'b0);
    tick(); tick();
    check("retry_ok_done", reg_done_cnt, 64'd2);
    check("retry_ok_nofail", reg_fail_cnt, 64'd0);

    // Retry exhaustion: four R_ERR -> four frames, one fail
    push_reg(0, 5, 32'hB100_0000, 4);
    for (int r = 0; r < 3; r++) begin
      check_frame("exh_frame", 0, 5, 32'hB100_0000, 4);
      link(1'b1);
    end
    check_frame("exh_frame_last", 0, 5, 32'hB100_0000, 4);
    link(1'b1);
    check("exh_fail_pulse", {63'b0, o_reg_fail}, 64'd1);
    repeat (10) tick();
    check("exh_fail_cnt", reg_fail_cnt, 64'd1);
    check("exh_done_cnt", reg_done_cnt, 64'd2);
    check("exh_no_5th_frame", out_q.size(), 64'd0);

    // Data frame wins arbitration; R_ERR is reported, no replay
    i_txgate = 1'b1;
    i_data_valid = 1'b1; i_data_data = 32'hD000_0000; i_data_last = 1'b0;
    i_reg_valid = 1'b1; i_reg_data = 32'h0000_1234; i_reg_last = 1'b1;
    tick();
    i_reg_valid = 1'b0; i_reg_last = 1'b0;
    check("data_prio_no_regload", {63'b0, o_reg_ready}, 64'd0);
    tick();
    check("data_hdr_n2", {31'b0, o_valid, o_last, o_data}, {31'b0, 1'b1, 1'b0, 32'h0000_0046});
    tick();
    check("data_p0_n3", {31'b0, o_valid, o_data}, {31'b0, 1'b1, 32'hD000_0000});
    push_data(1, 2, 32'hD000_0000, 2, 1'b0);
    wait_words(4);
    pop_hdr("data_hdr_word");
    check_frame("data_payload", 0, 3, 32'hD000_0000, 2);
    link(1'b1);
    check("data_done_err", {62'b0, o_data_done, o_data_err}, 64'd3);
    i_txgate = 1'b0;
    repeat (10) tick();
    check("data_no_replay", out_q.size(), 64'd0);
    check("data_idle", {63'b0, o_busy}, 64'd0);

    // Backpressure with source gaps
    bp_en = 1'b1;
    i_txgate = 1'b1;
    push_data(0, 4, 32'hE000_0000, 3, 1'b1);
    i_txgate = 1'b0;
    wait_words(5);
    pop_hdr("bp_hdr_word");
    check_frame("bp_payload", 0, 4, 32'hE000_0000, 3);
    link(1'b0);
    bp_en = 1'b0;
    i_ready = 1'b1;
    tick(); tick();
    check("bp_done_cnt", data_done_cnt, 64'd2);
    check("bp_done_err", {63'b0, last_data_err}, 64'd0);
    check("bp_no_extra", out_q.size(), 64'd0);

    // Buffer overflow: 8 words without last, then the rest as a new FIS
    push_reg(0, 8, 32'hC000_0000, -1);
    check_frame("ovf_frame", 0, 8, 32'hC000_0000, 7);
    link(1'b0);
    push_reg(8, 2, 32'hC000_0000, 9);
    check_frame("ovf_rest", 8, 2, 32'hC000_0000, 9);
    link(1'b0);
    tick(); tick();
    check("ovf_done_cnt", reg_done_cnt, 64'd4);

    // Async reset in the middle of REG_SEND
    push_reg(0, 5, 32'hF000_0000, 4);
    wait_words(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {30'b0, o_busy, o_valid, o_last, o_data}, 64'd0);
    tick();
    rst_n = 1'b1;
    out_q.delete();
    tick(); tick();
    check("arst_idle", {62'b0, o_busy, o_valid}, 64'd0);
    push_reg(0, 5, 32'hF000_0000, 4);
    check_frame("arst_refire", 0, 5, 32'hF000_0000, 4);
    link(1'b0);
    tick(); tick();
    check("arst_done_cnt", reg_done_cnt, 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
